// File: rtl/aquila_dbus_router.sv
// Aquila data-bus router: base/mask segment decode, one outstanding request, registered response.
// Optional target timeout is enabled by defining AQUILA_DBUS_TIMEOUT_EN.
module aquila_dbus_router #(
  parameter int                            XLEN           = 32,
  parameter int                            N_PORTS        = 4,
  parameter int                            SEG_BITS       = 4,
  parameter logic [N_PORTS*SEG_BITS-1:0]   BASE_MAP       = {4'hF, 4'hC, 4'h8, 4'h0},
  parameter logic [N_PORTS*SEG_BITS-1:0]   MASK_MAP       = {4'hF, 4'hF, 4'hC, 4'hF},
  parameter int                            TIMEOUT_CYCLES = 1024,
  parameter logic [XLEN-1:0]               ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      c_strobe_i,
  input  logic [XLEN-1:0]           c_addr_i,
  input  logic                      c_rw_i,
  input  logic [XLEN/8-1:0]         c_be_i,
  input  logic [XLEN-1:0]           c_data_i,
  output logic [XLEN-1:0]           c_data_o,
  output logic                      c_ready_o,
  output logic                      c_err_o,
  output logic [N_PORTS-1:0]        s_strobe_o,
  output logic [XLEN-1:0]           s_addr_o,
  output logic                      s_rw_o,
  output logic [XLEN/8-1:0]         s_be_o,
  output logic [XLEN-1:0]           s_data_o,
  input  logic [N_PORTS*XLEN-1:0]   s_data_i,
  input  logic [N_PORTS-1:0]        s_ready_i,
  output logic [XLEN-1:0]           err_addr_o,
  output logic                      proto_err_o
);

  localparam int BE_W  = XLEN / 8;
  localparam int SEL_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_e;

  state_e              state_q,     state_d;
  logic [SEL_W-1:0]    sel_q,       sel_d;
  logic [N_PORTS-1:0]  s_strobe_q,  s_strobe_d;
  logic [XLEN-1:0]     s_addr_q,    s_addr_d;
  logic                s_rw_q,      s_rw_d;
  logic [BE_W-1:0]     s_be_q,      s_be_d;
  logic [XLEN-1:0]     s_data_q,    s_data_d;
  logic [XLEN-1:0]     c_data_q,    c_data_d;
  logic                c_ready_q,   c_ready_d;
  logic                c_err_q,     c_err_d;
  logic [XLEN-1:0]     err_addr_q,  err_addr_d;
  logic                proto_err_q, proto_err_d;

`ifdef AQUILA_DBUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  logic [SEG_BITS-1:0] seg;
  logic                hit;
  logic [SEL_W-1:0]    hit_idx;
  logic                sel_ready;
  logic [XLEN-1:0]     sel_rdata;

  assign seg = c_addr_i[XLEN-1 -: SEG_BITS];

  // Scan from the top so the lowest matching port is the last assignment and wins.
  // NOTE: every signal written in an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if ((seg & MASK_MAP[k*SEG_BITS +: SEG_BITS]) == BASE_MAP[k*SEG_BITS +: SEG_BITS]) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(k);
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sel_ready = s_ready_i[k];
        sel_rdata = s_data_i[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    s_strobe_d  = '0;
    s_addr_d    = s_addr_q;
    s_rw_d      = s_rw_q;
    s_be_d      = s_be_q;
    s_data_d    = s_data_q;
    c_data_d    = c_data_q;
    c_ready_d   = 1'b0;
    c_err_d     = 1'b0;
    err_addr_d  = err_addr_q;
    proto_err_d = proto_err_q;
`ifdef AQUILA_DBUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (c_strobe_i) begin
          if (hit) begin
            state_d    = S_WAIT;
            sel_d      = hit_idx;
            s_strobe_d = N_PORTS'(1) << hit_idx;
            s_addr_d   = c_addr_i;
            s_rw_d     = c_rw_i;
            s_be_d     = c_be_i;
            s_data_d   = c_data_i;
`ifdef AQUILA_DBUS_TIMEOUT_EN
            cnt_d      = '0;
`endif
          end else begin
            state_d    = S_ERR;
            err_addr_d = c_addr_i;
            c_data_d   = ERR_DATA;
            c_ready_d  = 1'b1;
            c_err_d    = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (c_strobe_i) proto_err_d = 1'b1;
        if (sel_ready) begin
          state_d   = S_RESP;
          c_data_d  = sel_rdata;
          c_ready_d = 1'b1;
        end
`ifdef AQUILA_DBUS_TIMEOUT_EN
        // Ready in the expiry cycle was handled above and takes priority.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = S_ERR;
          err_addr_d = s_addr_q;
          c_data_d   = ERR_DATA;
          c_ready_d  = 1'b1;
          c_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_ERR: begin
        if (c_strobe_i) proto_err_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      s_strobe_q  <= '0;
      s_addr_q    <= '0;
      s_rw_q      <= 1'b0;
      s_be_q      <= '0;
      s_data_q    <= '0;
      c_data_q    <= '0;
      c_ready_q   <= 1'b0;
      c_err_q     <= 1'b0;
      err_addr_q  <= '0;
      proto_err_q <= 1'b0;
`ifdef AQUILA_DBUS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      s_strobe_q  <= s_strobe_d;
      s_addr_q    <= s_addr_d;
      s_rw_q      <= s_rw_d;
      s_be_q      <= s_be_d;
      s_data_q    <= s_data_d;
      c_data_q    <= c_data_d;
      c_ready_q   <= c_ready_d;
      c_err_q     <= c_err_d;
      err_addr_q  <= err_addr_d;
      proto_err_q <= proto_err_d;
`ifdef AQUILA_DBUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign c_data_o    = c_data_q;
  assign c_ready_o   = c_ready_q;
  assign c_err_o     = c_err_q;
  assign s_strobe_o  = s_strobe_q;
  assign s_addr_o    = s_addr_q;
  assign s_rw_o      = s_rw_q;
  assign s_be_o      = s_be_q;
  assign s_data_o    = s_data_q;
  assign err_addr_o  = err_addr_q;
  assign proto_err_o = proto_err_q;

endmodule
